lsq_monitor: RTL
================

# lsq_monitor

Parametrised, clocked successor to the three-input `l`/`s`/`q` NAND block. It evaluates the `l & s & q` condition on `CHANNELS` independent channels and registers the per-channel NAND output `m`. Each channel raises an alarm once its condition has persisted for `HOLD` consecutive cycles, and a saturating counter tallies alarm events. It sits between raw status inputs and the downstream status/interrupt logic.

## Interface
- `CHANNELS`, default 4: number of independent channels, legal range 1–32.
- `HOLD`, default 3: consecutive sampled-high edges required to raise an alarm, legal range 1–255.
- `COUNT_W`, default 8: width of `alarm_count`.
- `clk` in 1: single clock; everything updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `l` in `CHANNELS`: per-channel input l.
- `s` in `CHANNELS`: per-channel input s.
- `q` in `CHANNELS`: per-channel input q.
- `ack` in `CHANNELS`: per-channel alarm acknowledge, one-cycle pulse.
- `m` out `CHANNELS`: registered `~(l & s & q)` per channel.
- `alarm` out `CHANNELS`: per-channel alarm, driven from state.
- `any_alarm` out 1: OR of `alarm`, same cycle as `alarm`.
- `alarm_count` out `COUNT_W`: saturating count of ALARM entries.

## Operation
- `cond[i] = l[i] & s[i] & q[i]`. `m[i]` is register(`~cond[i]`).
- Per-channel FSM, with hold counter `cnt` of width `$clog2(HOLD+1)`:
  - IDLE, `cnt=0`:
    - `cond` and `HOLD==1` → ALARM.
    - `cond` → ARMING, `cnt=1`.
    - else stay.
  - ARMING:
    - `!cond` → IDLE, `cnt=0`.
    - `cond` and `cnt==HOLD-1` → ALARM.
    - else `cnt++`.
  - ALARM: exit rules are set by the configuration macro (see Configuration). On any exit, `cnt=0`.
- `alarm[i] = (state==ALARM)`.
- `ack[i]` has an effect only in ALARM. It is ignored in IDLE and ARMING, including on the edge where the channel enters ALARM (entry wins).
- `alarm_count` adds the number of channels transitioning into ALARM on an edge (popcount, 0..`CHANNELS`). It saturates at `2^COUNT_W-1` and never wraps. Counting is not dependent on `ack`.
- After leaving ALARM, re-arming requires a fresh `HOLD` edges.

## Timing
- Reset values: `m` all 1, `alarm` 0, `any_alarm` 0, `alarm_count` 0, all FSMs IDLE with `cnt=0`.
- Reset overrides all other inputs on that edge.
- `m` latency: 1 cycle after the edge that samples the inputs.
- Alarm latency: with `cond` sampled high on edges k..k+HOLD-1, `alarm` is 1 after edge k+HOLD-1.
  - For `HOLD=3`: high on edges 1, 2, 3 gives `alarm` after edge 3.
- A single low sample during ARMING restarts the count.
- Reset during ARMING or ALARM returns to IDLE; the partial count is lost. `alarm_count` clears.
- `alarm_count` updates on the same edge `alarm` rises.
- `ack` and `cond` high together in ALARM (sticky build): exit to IDLE. The next edge may enter ARMING.

## Configuration
- `LSQ_MONITOR_STICKY_EN` defined: ALARM is sticky.
  - Exit only on `ack[i]`, regardless of `cond`.
- `LSQ_MONITOR_STICKY_EN` undefined: ALARM is level-following.
  - Exit on the first edge with `!cond[i]`.
  - `ack` is ignored entirely.
- The `m` and `alarm_count` behaviour is identical in both builds.

## Structure
- Package `lsq_monitor_pkg` holds:
  - state typedef `lsq_state_t` = {IDLE=2'd0, ARMING=2'd1, ALARM=2'd2};
  - the default constants for `HOLD` and `COUNT_W`.
- Sub-module `lsq_channel`, parametrised by `HOLD`, contains one channel's FSM, hold counter and `m` register. It is generated `CHANNELS` times.
- The top level contains the popcount of ALARM entries, the saturating `alarm_count`, and the `any_alarm` reduction.

## Test plan
1. Reset with all inputs at 1 → `m=4'hF`, `alarm=0`. Release reset, ch0 `l=s=q=1` → `m[0]=0` one cycle later; ch0 `q=0` → `m[0]=1` one cycle later.
2. `HOLD=3`: ch1 `cond` high for 2 edges, then low → `alarm[1]` stays 0. `cond` high for 3 edges → `alarm[1]=1` and `any_alarm=1` after the 3rd edge; `alarm_count=1`.
3. Sticky build: from step 2, drop `cond` → `alarm[1]` stays 1. Pulse `ack[1]` → 0 after that edge. Non-sticky build: drop `cond` → `alarm[1]=0` next edge, `ack` has no effect.
4. All 4 channels' `cond` rise together for 3 edges → `alarm=4'hF`, `alarm_count` increases by exactly 4 on one edge.
5. Repeated alarm events with `alarm_count` at 254: two simultaneous entries → 255, then further entries → stays 255.
6. Ch2 in ARMING with `cnt=2`, `reset` pulsed for one edge with `cond` held high → `alarm[2]` rises only after 3 further high edges; `alarm_count=0` then 1.

Source files
------------

// File: rtl/lsq_monitor_pkg.sv
// Shared state encoding and default sizing for the lsq_monitor channels.
// Purely declarative: no logic, no latency, no backpressure.
package lsq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ALARM  = 2'd2
    } lsq_state_t;

    localparam int HOLD_DEFAULT    = 3;
    localparam int COUNT_W_DEFAULT = 8;

    // Width of a counter that must reach HOLD inclusive.
    function automatic int hold_cnt_width(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/lsq_channel.sv
// One channel: registered NAND output, HOLD-edge persistence FSM; m and alarm valid 1 cycle after the sampling edge.
// No backpressure: inputs are sampled every edge; enter flags the edge that moves this channel into ALARM.
module lsq_channel
    import lsq_monitor_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic l,
    input  logic s,
    input  logic q,
    input  logic ack,
    output logic m,
    output logic alarm,
    output logic enter
);

    localparam int              CW   = hold_cnt_width(HOLD);
    localparam logic [CW-1:0]   LAST = CW'(HOLD - 1);

    lsq_state_t    state;
    logic [CW-1:0] cnt;
    logic          cond;

    assign cond  = l & s & q;
    assign alarm = (state == ALARM);

    // Combinational entry strobe so the top-level count moves on the same edge alarm rises.
    assign enter = cond && (state != ALARM) &&
                   ((HOLD == 1) || ((state == ARMING) && (cnt == LAST)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            m     <= 1'b1;
        end else begin
            m <= ~cond;
            case (state)
                IDLE: begin
                    if (cond) begin
                        if (HOLD == 1) begin
                            state <= ALARM;
                            cnt   <= '0;
                        end else begin
                            state <= ARMING;
                            cnt   <= CW'(1);
                        end
                    end
                end
                ARMING: begin
                    if (!cond) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= ALARM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ALARM: begin
`ifdef LSQ_MONITOR_STICKY_EN
                    if (ack) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
`else
                    if (!cond) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef LSQ_MONITOR_STICKY_EN
    // Level-following alarms never look at the acknowledge.
    logic unused_ack;
    assign unused_ack = ack;
`endif

endmodule

// File: rtl/lsq_monitor.sv
// CHANNELS-wide l&s&q persistence monitor with saturating alarm-entry count; outputs 1 cycle after sampling edge.
// No backpressure; LSQ_MONITOR_STICKY_EN makes alarms hold until ack, otherwise they follow the condition.
module lsq_monitor
    import lsq_monitor_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int HOLD     = HOLD_DEFAULT,
    parameter int COUNT_W  = COUNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] l,
    input  logic [CHANNELS-1:0] s,
    input  logic [CHANNELS-1:0] q,
    input  logic [CHANNELS-1:0] ack,
    output logic [CHANNELS-1:0] m,
    output logic [CHANNELS-1:0] alarm,
    output logic                any_alarm,
    output logic [COUNT_W-1:0]  alarm_count
);

    localparam int PW = $clog2(CHANNELS + 1);
    localparam int SW = ((COUNT_W > PW) ? COUNT_W : PW) + 1;
    localparam logic [SW-1:0] MAX = SW'({COUNT_W{1'b1}});

    logic [CHANNELS-1:0] enter;
    logic [PW-1:0]       n_enter;
    logic [SW-1:0]       sum;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        lsq_channel #(
            .HOLD (HOLD)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .l     (l[i]),
            .s     (s[i]),
            .q     (q[i]),
            .ack   (ack[i]),
            .m     (m[i]),
            .alarm (alarm[i]),
            .enter (enter[i])
        );
    end

    always_comb begin
        n_enter = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n_enter = n_enter + PW'(enter[i]);
        end
    end

    // Extra headroom bit lets the clamp see an overflow instead of a wrap.
    assign sum = SW'(alarm_count) + SW'(n_enter);

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_count <= '0;
        end else if (sum > MAX) begin
            alarm_count <= '1;
        end else begin
            alarm_count <= sum[COUNT_W-1:0];
        end
    end

    assign any_alarm = |alarm;

endmodule
